// File: rtl/rat_pkg.sv
// Constants shared between the RAT control unit and the flag/interrupt stage.
package rat_pkg;

  localparam logic FLG_SRC_ALU  = 1'b0;
  localparam logic FLG_SRC_SHAD = 1'b1;

  // Selects the flag load source from FLG_LD_SEL.
  function automatic logic flg_src(input logic sel, input logic alu_val, input logic shad_val);
    return (sel == FLG_SRC_SHAD) ? shad_val : alu_val;
  endfunction

endpackage

// File: rtl/int_sync.sv
// Synchroniser chain for an asynchronous request line with a registered
// rising-edge detector on the synchronised output.
module int_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ASYNC_IN,
  output logic EDGE_OUT
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ASYNC_IN};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign EDGE_OUT = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/flag_int_unit.sv
// C/Z flags with shadow copies, interrupt-enable flag and the pending
// interrupt latch feeding the RAT control unit.
module flag_int_unit
  import rat_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ALU_C,
  input  logic ALU_Z,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_LD_SEL,
  input  logic FLG_SHAD_LD,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INT_ACK,
  input  logic INT_IN,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic INT_CU
);

  logic c_q, c_d;
  logic z_q, z_d;
  logic shad_c_q, shad_c_d;
  logic shad_z_q, shad_z_d;
  logic i_q, i_d;
  logic pend_q, pend_d;
  logic int_edge;

  int_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_int_sync (
    .CLK     (CLK),
    .RESET   (RESET),
    .ASYNC_IN(INT_IN),
    .EDGE_OUT(int_edge)
  );

  always_comb begin
    c_d = c_q;
    if (FLG_C_CLR) begin
      c_d = 1'b0;
    end else if (FLG_C_SET) begin
      c_d = 1'b1;
    end else if (FLG_C_LD) begin
      c_d = flg_src(FLG_LD_SEL, ALU_C, shad_c_q);
    end

    z_d = FLG_Z_LD ? flg_src(FLG_LD_SEL, ALU_Z, shad_z_q) : z_q;

    // Shadow takes the pre-edge flags, so a simultaneous restore swaps.
    shad_c_d = FLG_SHAD_LD ? c_q : shad_c_q;
    shad_z_d = FLG_SHAD_LD ? z_q : shad_z_q;

    i_d = i_q;
    if (I_CLR) begin
      i_d = 1'b0;
    end else if (I_SET) begin
      i_d = 1'b1;
    end

    // A fresh edge wins over an acknowledge so the new request survives.
    pend_d = int_edge | (pend_q & ~INT_ACK);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      shad_c_q <= 1'b0;
      shad_z_q <= 1'b0;
      i_q      <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      c_q      <= c_d;
      z_q      <= z_d;
      shad_c_q <= shad_c_d;
      shad_z_q <= shad_z_d;
      i_q      <= i_d;
      pend_q   <= pend_d;
    end
  end

  assign C_FLAG = c_q;
  assign Z_FLAG = z_q;
  assign I_FLAG = i_q;
  assign INT_CU = pend_q & i_q;

endmodule

// File: tb/tb_flag_int_unit.sv
// Scoreboard bench for flag_int_unit: directed scenarios then random stimulus,
// checked against a behavioural model of flags, shadow and interrupt request.
module tb_flag_int_unit;

  localparam int unsigned S = 2;

  logic CLK;
  logic RESET, ALU_C, ALU_Z, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD;
  logic FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INT_ACK, INT_IN;
  logic C_FLAG, Z_FLAG, I_FLAG, INT_CU;

  flag_int_unit #(
    .SYNC_STAGES(S)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ALU_C      (ALU_C),
    .ALU_Z      (ALU_Z),
    .FLG_C_SET  (FLG_C_SET),
    .FLG_C_CLR  (FLG_C_CLR),
    .FLG_C_LD   (FLG_C_LD),
    .FLG_Z_LD   (FLG_Z_LD),
    .FLG_LD_SEL (FLG_LD_SEL),
    .FLG_SHAD_LD(FLG_SHAD_LD),
    .I_SET      (I_SET),
    .I_CLR      (I_CLR),
    .INT_ACK    (INT_ACK),
    .INT_IN     (INT_IN),
    .C_FLAG     (C_FLAG),
    .Z_FLAG     (Z_FLAG),
    .I_FLAG     (I_FLAG),
    .INT_CU     (INT_CU)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Staged inputs for the next cycle
  logic n_reset, n_alu_c, n_alu_z, n_c_set, n_c_clr, n_c_ld, n_z_ld;
  logic n_sel, n_shad_ld, n_i_set, n_i_clr, n_ack, n_int_in;

  // Reference model state
  bit m_c, m_z, m_sc, m_sz, m_i, m_pend;
  bit smp[$];  // INT_IN as seen at recent edges, newest first

  typedef struct {
    logic [3:0]  exp;
    int unsigned idx;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  int unsigned n_vec = 0;
  int unsigned n_fail = 0;
  int unsigned n_push = 0;

  task automatic clear_staged();
    n_reset = 0; n_alu_c = 0; n_alu_z = 0; n_c_set = 0; n_c_clr = 0; n_c_ld = 0;
    n_z_ld = 0; n_sel = 0; n_shad_ld = 0; n_i_set = 0; n_i_clr = 0; n_ack = 0;
  endtask

  task automatic model_edge();
    bit edge_seen, src_c, src_z, new_c, new_z;
    // Synchronised INT_IN lags by S edges; a request is a 0->1 step in that lagged view
    edge_seen = smp[S-1] & ~smp[S];
    if (n_reset) begin
      m_c = 0; m_z = 0; m_sc = 0; m_sz = 0; m_i = 0; m_pend = 0;
      smp.delete();
      for (int k = 0; k <= S; k++) smp.push_back(1'b0);
    end else begin
      src_c = n_sel ? m_sc : n_alu_c;
      src_z = n_sel ? m_sz : n_alu_z;
      new_c = n_c_clr ? 1'b0 : n_c_set ? 1'b1 : n_c_ld ? src_c : m_c;
      new_z = n_z_ld ? src_z : m_z;
      if (n_shad_ld) begin
        m_sc = m_c;
        m_sz = m_z;
      end
      m_c = new_c;
      m_z = new_z;
      m_i = n_i_clr ? 1'b0 : n_i_set ? 1'b1 : m_i;
      m_pend = edge_seen | (m_pend & ~n_ack);
      smp.push_front(n_int_in);
      void'(smp.pop_back());
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge CLK);
    #1;
    RESET = n_reset; ALU_C = n_alu_c; ALU_Z = n_alu_z; FLG_C_SET = n_c_set;
    FLG_C_CLR = n_c_clr; FLG_C_LD = n_c_ld; FLG_Z_LD = n_z_ld; FLG_LD_SEL = n_sel;
    FLG_SHAD_LD = n_shad_ld; I_SET = n_i_set; I_CLR = n_i_clr; INT_ACK = n_ack;
    INT_IN = n_int_in;
    model_edge();
    e.exp = {m_c, m_z, m_i, m_pend & m_i};
    e.idx = n_push;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic idle(input int n);
    clear_staged();
    for (int k = 0; k < n; k++) step();
  endtask

  // Monitor: outputs are valid every cycle; each negedge checks the preceding edge
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      n_vec++;
      if ({C_FLAG, Z_FLAG, I_FLAG, INT_CU} !== cur.exp) begin
        n_fail++;
        $display("FAIL vec%0d {C,Z,I,INT_CU}: got %b%b%b%b want %b", cur.idx,
                 C_FLAG, Z_FLAG, I_FLAG, INT_CU, cur.exp);
      end
    end
  end

  initial begin
    RESET = 1; ALU_C = 0; ALU_Z = 0; FLG_C_SET = 0; FLG_C_CLR = 0; FLG_C_LD = 0;
    FLG_Z_LD = 0; FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
    INT_IN = 0;
    for (int k = 0; k <= S; k++) smp.push_back(1'b0);
    n_int_in = 0;
    clear_staged();

    // Reset with every input high
    n_reset = 1; n_alu_c = 1; n_alu_z = 1; n_c_set = 1; n_c_clr = 1; n_c_ld = 1;
    n_z_ld = 1; n_sel = 1; n_shad_ld = 1; n_i_set = 1; n_i_clr = 1; n_ack = 1;
    n_int_in = 1;
    for (int k = 0; k < 3; k++) step();
    idle(6);
    n_int_in = 0;
    idle(3);
    n_ack = 1; step();

    // C priority and Z load
    clear_staged(); n_alu_c = 1; n_c_ld = 1; step();
    clear_staged(); n_c_set = 1; n_c_clr = 1; step();
    clear_staged(); n_c_set = 1; step();
    clear_staged(); n_alu_z = 1; n_z_ld = 1; step();
    idle(1);

    // Shadow save, ALU load, restore, then swap
    clear_staged(); n_c_set = 1; n_z_ld = 1; n_alu_z = 0; step();
    clear_staged(); n_shad_ld = 1; step();
    clear_staged(); n_alu_c = 0; n_alu_z = 1; n_c_ld = 1; n_z_ld = 1; step();
    clear_staged(); n_sel = 1; n_c_ld = 1; n_z_ld = 1; step();
    clear_staged(); n_sel = 1; n_c_ld = 1; n_z_ld = 1; n_shad_ld = 1; step();
    idle(1);
    clear_staged(); n_sel = 1; n_c_ld = 1; n_z_ld = 1; step();
    idle(1);

    // Interrupt latency and acknowledge with INT_IN held
    clear_staged(); n_i_set = 1; step();
    n_int_in = 1; idle(5);
    clear_staged(); n_ack = 1; step();
    idle(4);
    n_int_in = 0; idle(3);

    // Masked request, enabled later
    clear_staged(); n_i_clr = 1; step();
    n_int_in = 1; idle(1);
    n_int_in = 0; idle(20);
    clear_staged(); n_i_set = 1; step();
    idle(2);

    // Edge detect coinciding with acknowledge, then reset while pending
    n_int_in = 1; idle(2);
    clear_staged(); n_ack = 1; step();
    idle(3);
    clear_staged(); n_reset = 1; step();
    n_int_in = 0; idle(3);

    // Random phase
    for (int k = 0; k < 1500; k++) begin
      n_reset   = ($urandom_range(63) == 0);
      n_alu_c   = $urandom_range(1);
      n_alu_z   = $urandom_range(1);
      n_c_set   = ($urandom_range(3) == 0);
      n_c_clr   = ($urandom_range(3) == 0);
      n_c_ld    = ($urandom_range(2) == 0);
      n_z_ld    = ($urandom_range(2) == 0);
      n_sel     = $urandom_range(1);
      n_shad_ld = ($urandom_range(3) == 0);
      n_i_set   = ($urandom_range(7) == 0);
      n_i_clr   = ($urandom_range(15) == 0);
      n_ack     = ($urandom_range(7) == 0);
      if ($urandom_range(5) == 0) n_int_in = ~n_int_in;
      step();
    end

    @(negedge CLK);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
